// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg: shared state encoding and default sizing for the ring-oscillator measurement engine
package ro_meas_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;
  localparam int DEF_CNT_W = 24;
  localparam int DEF_GATE_W = 20;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int NUM_CH = 16;
  localparam int SEL_W = $clog2(NUM_CH);
endpackage

// File: rtl/ro_edge_sync.sv
// ro_edge_sync: multi-flop synchroniser for an asynchronous input followed by a rising-edge detect
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_i};
      prev <= sync[SYNC_STAGES-1];
    end
  end
  assign rise_o = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/ro_freq_counter.sv
// ro_freq_counter: enables a ring oscillator, waits a settle time, then counts its rising edges
// over a programmable gate window and reports the saturating count with a done pulse.
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int GATE_W = DEF_GATE_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              meas_req_i,
  input  logic [SEL_W-1:0]  meas_sel_i,
  input  logic [GATE_W-1:0] gate_cycles_i,
  input  logic              ro_i,
  output logic              ro_start_o,
  output logic [SEL_W-1:0]  ro_sel_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o
);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
  state_t state;
  logic [GATE_W-1:0] gate_cnt;
  logic [ST_W-1:0] settle_cnt;
  logic [CNT_W-1:0] edge_cnt, cnt_nxt;
  logic ovf, ovf_nxt, rise, hit, enter_done;
  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(wb_clk_i),
    .rst_n(wb_rst_ni),
    .async_i(ro_i),
    .rise_o(rise)
  );
  // result is captured from the next-state count so an edge in the final gate cycle is included
  always_comb begin
    hit = (state == MEASURE) && rise;
    cnt_nxt = (hit && !(&edge_cnt)) ? edge_cnt + 1'b1 : edge_cnt;
    ovf_nxt = ovf | (hit && (&edge_cnt));
    enter_done = ((state == SETTLE) && (settle_cnt == ST_W'(1)) && (gate_cnt == '0)) ||
                 ((state == MEASURE) && (gate_cnt == GATE_W'(1)));
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
      gate_cnt <= '0;
      settle_cnt <= '0;
      edge_cnt <= '0;
      ovf <= 1'b0;
      ro_start_o <= 1'b0;
      ro_sel_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      count_o <= '0;
      ovf_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (meas_req_i) begin
          ro_sel_o <= meas_sel_i;
          gate_cnt <= gate_cycles_i;
          edge_cnt <= '0;
          ovf <= 1'b0;
          ro_start_o <= 1'b1;
          busy_o <= 1'b1;
          settle_cnt <= ST_W'(SETTLE_CYCLES);
          state <= SETTLE;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt == ST_W'(1)) state <= (gate_cnt == '0) ? DONE : MEASURE;
        end
        MEASURE: begin
          edge_cnt <= cnt_nxt;
          ovf <= ovf_nxt;
          gate_cnt <= gate_cnt - 1'b1;
          if (gate_cnt == GATE_W'(1)) state <= DONE;
        end
        DONE: begin
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (enter_done) begin
        done_o <= 1'b1;
        count_o <= cnt_nxt;
        ovf_o <= ovf_nxt;
        ro_start_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: directed checks of latency, counting, saturation, reset and request handling
module tb_ro_freq_counter;
  localparam int S = 16;
  logic wb_clk_i = 1'b0;
  logic wb_rst_ni = 1'b1;
  logic meas_req_i = 1'b0;
  logic [3:0] meas_sel_i = '0;
  logic [19:0] gate_cycles_i = '0;
  logic ro_i = 1'b0;
  logic ro_start_o, busy_o, done_o, ovf_o;
  logic [3:0] ro_sel_o;
  logic [23:0] count_o;
  logic start8, busy8, done8, ovf8;
  logic [3:0] sel8;
  logic [7:0] count8;
  int n_chk = 0;
  int n_fail = 0;
  int ro_half = 50;
  logic ro_level = 1'b0;

  ro_freq_counter dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .meas_req_i(meas_req_i),
    .meas_sel_i(meas_sel_i), .gate_cycles_i(gate_cycles_i), .ro_i(ro_i),
    .ro_start_o(ro_start_o), .ro_sel_o(ro_sel_o), .busy_o(busy_o),
    .done_o(done_o), .count_o(count_o), .ovf_o(ovf_o)
  );
  ro_freq_counter #(.CNT_W(8)) dut8 (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .meas_req_i(meas_req_i),
    .meas_sel_i(meas_sel_i), .gate_cycles_i(gate_cycles_i), .ro_i(ro_i),
    .ro_start_o(start8), .ro_sel_o(sel8), .busy_o(busy8),
    .done_o(done8), .count_o(count8), .ovf_o(ovf8)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // oscillator model: toggles every ro_half ns, or sits at ro_level when ro_half is 0
  initial begin
    #3;
    forever begin
      if (ro_half == 0) begin
        ro_i = ro_level;
        #1;
      end else begin
        #(ro_half) ro_i = ~ro_i;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // called at the negedge of cycle 1; returns the cycle index where done_o is seen (-1 on timeout)
  task automatic wait_done(input bit poke, input bit hold, output int lat, output int hi);
    lat = 1;
    hi = 0;
    while (!done_o && lat < 5000) begin
      hi += int'(ro_start_o);
      meas_req_i = hold || (poke && (lat == 3 || lat == S + 2));
      if (hold && lat == 10) meas_sel_i = 4'd9;
      @(negedge wb_clk_i);
      lat++;
    end
    if (!hold) meas_req_i = 1'b0;
    if (!done_o) lat = -1;
  endtask

  task automatic run(input logic [3:0] sel, input logic [19:0] gate, input bit poke,
                     output int lat, output int hi);
    @(negedge wb_clk_i);
    meas_req_i = 1'b1;
    meas_sel_i = sel;
    gate_cycles_i = gate;
    @(negedge wb_clk_i);
    meas_req_i = 1'b0;
    meas_sel_i = ~sel;
    gate_cycles_i = '1;
    check("sel_cycle1", ro_sel_o, sel);
    check("start_cycle1", ro_start_o, 1);
    check("busy_cycle1", busy_o, 1);
    wait_done(poke, 1'b0, lat, hi);
  endtask

  initial begin
    int lat, hi, extra;
    wb_rst_ni = 1'b0;
    @(negedge wb_clk_i);
    check("rst_start", ro_start_o, 0);
    check("rst_sel", ro_sel_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_count", count_o, 0);
    check("rst_ovf", ovf_o, 0);
    wb_rst_ni = 1'b1;

    run(4'd1, 20'd0, 1'b0, lat, hi);
    check("g0_latency", lat, S + 1);
    check("g0_start_cycles", hi, S);
    check("g0_count", count_o, 0);
    check("g0_ovf", ovf_o, 0);

    ro_half = 0;
    ro_level = 1'b1;
    repeat (5) @(negedge wb_clk_i);
    run(4'd2, 20'd500, 1'b0, lat, hi);
    check("static_latency", lat, S + 501);
    check("static_count", count_o, 0);

    ro_half = 50;
    run(4'd5, 20'd1000, 1'b0, lat, hi);
    check("t1_latency", lat, 1017);
    check("t1_start_cycles", hi, 1016);
    check("t1_start_at_done", ro_start_o, 0);
    check("t1_busy_at_done", busy_o, 1);
    check("t1_count_range", count_o >= 99 && count_o <= 101, 1);
    check("t1_ovf", ovf_o, 0);
    check("t1_count8_range", count8 >= 99 && count8 <= 101, 1);
    check("t1_ovf8", ovf8, 0);
    @(negedge wb_clk_i);
    check("t1_done_pulse", done_o, 0);
    check("t1_idle_busy", busy_o, 0);
    check("t1_sel_held", ro_sel_o, 5);

    ro_half = 20;
    run(4'd2, 20'd2000, 1'b0, lat, hi);
    check("sat_count8", count8, 255);
    check("sat_ovf8", ovf8, 1);
    check("sat_count24_range", count_o >= 499 && count_o <= 501, 1);
    check("sat_ovf24", ovf_o, 0);
    run(4'd2, 20'd100, 1'b0, lat, hi);
    check("post_sat_count8_range", count8 >= 24 && count8 <= 26, 1);
    check("post_sat_ovf8", ovf8, 0);

    ro_half = 50;
    @(negedge wb_clk_i);
    meas_req_i = 1'b1;
    meas_sel_i = 4'd4;
    gate_cycles_i = 20'd1000;
    @(negedge wb_clk_i);
    meas_req_i = 1'b0;
    repeat (S + 299) @(negedge wb_clk_i);
    check("pre_rst_busy", busy_o, 1);
    #2 wb_rst_ni = 1'b0;
    #1;
    check("arst_start", ro_start_o, 0);
    check("arst_sel", ro_sel_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_count", count_o, 0);
    extra = 0;
    repeat (4) begin
      @(negedge wb_clk_i);
      extra += int'(done_o);
    end
    wb_rst_ni = 1'b1;
    repeat (3) begin
      @(negedge wb_clk_i);
      extra += int'(done_o);
    end
    check("arst_no_done", extra, 0);
    run(4'd4, 20'd200, 1'b0, lat, hi);
    check("post_rst_latency", lat, S + 201);
    check("post_rst_count_range", count_o >= 19 && count_o <= 21, 1);

    @(negedge wb_clk_i);
    meas_req_i = 1'b1;
    meas_sel_i = 4'd3;
    gate_cycles_i = 20'd40;
    @(negedge wb_clk_i);
    check("hold_sel_run1", ro_sel_o, 3);
    wait_done(1'b0, 1'b1, lat, hi);
    check("hold_latency1", lat, S + 41);
    check("hold_sel_at_done", ro_sel_o, 3);
    @(negedge wb_clk_i);
    check("hold_idle_busy", busy_o, 0);
    check("hold_idle_sel", ro_sel_o, 3);
    @(negedge wb_clk_i);
    meas_req_i = 1'b0;
    check("hold_run2_busy", busy_o, 1);
    check("hold_run2_sel", ro_sel_o, 9);
    check("hold_run2_start", ro_start_o, 1);
    wait_done(1'b0, 1'b0, lat, hi);
    check("hold_latency2", lat, S + 41);

    run(4'd7, 20'd300, 1'b1, lat, hi);
    check("poke_latency", lat, S + 301);
    check("poke_count_range", count_o >= 29 && count_o <= 31, 1);
    extra = 0;
    repeat (6) begin
      @(negedge wb_clk_i);
      extra += int'(done_o);
    end
    check("poke_single_done", extra, 0);
    check("poke_idle_busy", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
